// File: rtl/hba_sonar_emu_defs.sv
// Shared definitions for the sonar responder emulator: FSM state encoding
// and the clock-to-microsecond divider derivation.
package hba_sonar_emu_defs;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG_HI,
    ST_HOLDOFF,
    ST_ECHO,
    ST_RECOVER
  } state_t;

  function automatic int unsigned calc_us_div(input int unsigned clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: counts 0..DIV-1, ticks on the last count, and
// restarts from 0 whenever restart is asserted.
module us_tick_gen #(
  parameter int unsigned DIV = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] count;

  assign tick = (count == PW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               count <= '0;
    else if (restart || tick) count <= '0;
    else                      count <= count + PW'(1);
  end

endmodule

// File: rtl/hba_sonar_emu.sv
// Ultrasonic ranging sensor emulator: qualifies a trigger pulse, waits a fixed
// hold-off and answers with an echo pulse whose width is echo_us microseconds.
module hba_sonar_emu
  import hba_sonar_emu_defs::*;
#(
  parameter int unsigned CLK_FREQUENCY   = 50_250_000,
  parameter int unsigned TRIG_MIN_US     = 10,
  parameter int unsigned HOLDOFF_US      = 500,
  parameter int unsigned ECHO_TIMEOUT_US = 38000,
  parameter int unsigned RECOVER_US      = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sonar_trig,
  output logic        sonar_echo,
  input  logic [15:0] echo_us,
  output logic        busy,
  output logic        trig_err,
  output logic [7:0]  pulse_count
);

  localparam int unsigned US_DIV   = calc_us_div(CLK_FREQUENCY);
  localparam int unsigned TRIG_CYC = TRIG_MIN_US * US_DIV;
  localparam int          TW       = $clog2(TRIG_CYC + 1);
  localparam int unsigned US_MAX   = max_u(max_u(HOLDOFF_US, RECOVER_US), ECHO_TIMEOUT_US);
  localparam int          CW       = int'(max_u(16, $clog2(US_MAX + 1)));

  state_t          state, next_state;
  logic            trig_m, trig_s, trig_q;
  logic            trig_rise, trig_fall;
  logic            accept, reject, restart, tick, us_done;
  logic [TW-1:0]   trig_width;
  logic [CW-1:0]   us_cnt, us_limit, w_reg, w_clamped;

  // NOTE: non-blocking assignments make the three flops shift as one
  // pipeline; blocking ones would collapse the synchronizer into a wire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_m <= 1'b0;
      trig_s <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      trig_m <= sonar_trig;
      trig_s <= trig_m;
      trig_q <= trig_s;
    end
  end

  assign trig_rise = trig_s & ~trig_q;
  assign trig_fall = ~trig_s & trig_q;

  us_tick_gen #(.DIV(US_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    case (state)
      ST_HOLDOFF: us_limit = CW'(HOLDOFF_US);
      ST_ECHO:    us_limit = w_reg;
      ST_RECOVER: us_limit = CW'(RECOVER_US);
      default:    us_limit = '0;
    endcase
  end

  assign us_done = tick && (us_cnt == us_limit - CW'(1));

  assign w_clamped = ((echo_us == 16'd0) || ({16'b0, echo_us} > ECHO_TIMEOUT_US))
                   ? CW'(ECHO_TIMEOUT_US) : CW'(echo_us);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    reject     = 1'b0;
    case (state)
      ST_IDLE:    if (trig_rise) next_state = ST_TRIG_HI;
      ST_TRIG_HI: if (trig_fall) begin
                    if (trig_width >= TW'(TRIG_CYC)) begin
                      accept     = 1'b1;
                      next_state = ST_HOLDOFF;
                    end else begin
                      reject     = 1'b1;
                      next_state = ST_IDLE;
                    end
                  end
      ST_HOLDOFF: if (us_done) next_state = ST_ECHO;
      ST_ECHO:    if (us_done) next_state = ST_RECOVER;
      ST_RECOVER: if (us_done) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
    // A trigger while an echo cycle is in flight is flagged and otherwise ignored.
    if (trig_rise && (state inside {ST_HOLDOFF, ST_ECHO, ST_RECOVER}))
      reject = 1'b1;
  end

  assign restart = (next_state != state);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sonar_echo  <= 1'b0;
      trig_err    <= 1'b0;
      pulse_count <= '0;
      w_reg       <= '0;
      trig_width  <= '0;
      us_cnt      <= '0;
    end else begin
      sonar_echo <= (next_state == ST_ECHO);
      trig_err   <= reject;
      if (accept) begin
        w_reg       <= w_clamped;
        pulse_count <= pulse_count + 8'd1;
      end
      // The rising-edge cycle is the first high cycle, so the count starts at 1.
      if (state == ST_IDLE)
        trig_width <= TW'(1);
      else if (state == ST_TRIG_HI && trig_s && trig_width < TW'(TRIG_CYC))
        trig_width <= trig_width + TW'(1);
      if (restart)   us_cnt <= '0;
      else if (tick) us_cnt <= us_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_hba_sonar_emu.sv
// Self-checking bench for hba_sonar_emu: vector table, randomized triggers
// against a timing model, and hand-written retrigger/latch/reset sequences.
module tb_hba_sonar_emu;

  localparam int DIV         = 10;
  localparam int TRIG_MIN_US = 10;
  localparam int HOLDOFF_US  = 20;
  localparam int TIMEOUT_US  = 300;
  localparam int RECOVER_US  = 50;
  localparam int TRIG_CYC    = TRIG_MIN_US * DIV;
  // Pin fall -> echo rise: 2 sync cycles, 1 edge-to-HOLDOFF cycle, then hold-off.
  localparam int RISE_DELAY  = 2 + 1 + HOLDOFF_US * DIV;
  localparam int RECOVER_CYC = RECOVER_US * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic        sonar_trig;
  logic        sonar_echo;
  logic [15:0] echo_us;
  logic        busy;
  logic        trig_err;
  logic [7:0]  pulse_count;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int echo_rises = 0, err_count = 0;
  int echo_rise_cyc = 0, echo_fall_cyc = 0, busy_fall_cyc = 0;
  logic echo_prev = 1'b0, busy_prev = 1'b0;
  int model_count = 0;

  typedef struct {
    int trig_cyc;
    int echo_val;
    bit accept;
    int echo_cyc;
  } vec_t;
  vec_t vecs[9];

  hba_sonar_emu #(
    .CLK_FREQUENCY   (10_000_000),
    .TRIG_MIN_US     (TRIG_MIN_US),
    .HOLDOFF_US      (HOLDOFF_US),
    .ECHO_TIMEOUT_US (TIMEOUT_US),
    .RECOVER_US      (RECOVER_US)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sonar_trig  (sonar_trig),
    .sonar_echo  (sonar_echo),
    .echo_us     (echo_us),
    .busy        (busy),
    .trig_err    (trig_err),
    .pulse_count (pulse_count)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sonar_echo && !echo_prev) begin
      echo_rise_cyc = cyc;
      echo_rises++;
    end
    if (!sonar_echo && echo_prev) echo_fall_cyc = cyc;
    if (!busy && busy_prev) busy_fall_cyc = cyc;
    if (trig_err === 1'b1) err_count++;
    echo_prev = sonar_echo;
    busy_prev = busy;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_echo_cycles(input int e);
    return ((e == 0) || (e > TIMEOUT_US)) ? TIMEOUT_US * DIV : e * DIV;
  endfunction

  task automatic drive_trig(input int n, output int pin_fall);
    @(negedge clk);
    sonar_trig = 1'b1;
    repeat (n) @(negedge clk);
    sonar_trig = 1'b0;
    pin_fall = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    repeat (4) @(negedge clk);
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle_timeout", busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic wait_echo(input logic level, input int budget);
    int k = 0;
    while (sonar_echo !== level && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sonar_echo !== level) check("echo_wait_timeout", sonar_echo, level);
  endtask

  task automatic do_txn(input int n, input int e, input bit acc, input int w_cyc);
    int rises0, errs0, pf;
    rises0  = echo_rises;
    errs0   = err_count;
    echo_us = 16'(e);
    drive_trig(n, pf);
    wait_idle(6000);
    if (acc) begin
      model_count = (model_count + 1) % 256;
      check("echo_count",      echo_rises - rises0, 1);
      check("echo_rise_delay", echo_rise_cyc - pf, RISE_DELAY);
      check("echo_width",      echo_fall_cyc - echo_rise_cyc, w_cyc);
      check("recover_time",    busy_fall_cyc - echo_fall_cyc, RECOVER_CYC);
      check("no_trig_err",     err_count - errs0, 0);
    end else begin
      check("reject_err_pulse", err_count - errs0, 1);
      check("reject_no_echo",   echo_rises - rises0, 0);
      check("reject_busy_fall", busy_fall_cyc - pf, 3);
    end
    check("pulse_count", pulse_count, model_count);
  endtask

  initial begin
    int pf, errs0, n, e;
    reset      = 1'b0;
    sonar_trig = 1'b0;
    echo_us    = 16'd0;
    repeat (3) @(negedge clk);
    check("reset_echo",        sonar_echo, 1'b0);
    check("reset_busy",        busy, 1'b0);
    check("reset_trig_err",    trig_err, 1'b0);
    check("reset_pulse_count", pulse_count, 8'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    vecs[0] = '{100, 100, 1'b1, 1000};
    vecs[1] = '{ 99, 100, 1'b0,    0};
    vecs[2] = '{100,   0, 1'b1, 3000};
    vecs[3] = '{100, 500, 1'b1, 3000};
    vecs[4] = '{100,   1, 1'b1,   10};
    vecs[5] = '{150,  37, 1'b1,  370};
    vecs[6] = '{ 10,  50, 1'b0,    0};
    vecs[7] = '{100, 300, 1'b1, 3000};
    vecs[8] = '{100, 301, 1'b1, 3000};
    for (int i = 0; i < 9; i++)
      do_txn(vecs[i].trig_cyc, vecs[i].echo_val, vecs[i].accept, vecs[i].echo_cyc);

    for (int i = 0; i < 5; i++) begin
      n = int'($urandom_range(90, 130));
      e = int'($urandom_range(0, 320));
      do_txn(n, e, n >= TRIG_CYC, model_echo_cycles(e));
    end

    // Retrigger during ECHO and RECOVER: two errors, latched width kept.
    errs0   = err_count;
    echo_us = 16'd100;
    drive_trig(100, pf);
    wait_echo(1'b1, 400);
    repeat (100) @(negedge clk);
    echo_us = 16'd200;
    drive_trig(100, pf);
    wait_echo(1'b0, 1200);
    repeat (100) @(negedge clk);
    drive_trig(100, pf);
    wait_idle(1000);
    model_count = (model_count + 1) % 256;
    check("retrig_errs",    err_count - errs0, 2);
    check("retrig_width",   echo_fall_cyc - echo_rise_cyc, 1000);
    check("retrig_recover", busy_fall_cyc - echo_fall_cyc, RECOVER_CYC);
    check("retrig_count",   pulse_count, model_count);
    do_txn(100, 200, 1'b1, 2000);

    // echo_us changed during HOLDOFF only affects the next acceptance.
    echo_us = 16'd100;
    drive_trig(100, pf);
    repeat (20) @(negedge clk);
    echo_us = 16'd250;
    wait_idle(2000);
    model_count = (model_count + 1) % 256;
    check("latch_width", echo_fall_cyc - echo_rise_cyc, 1000);
    check("latch_count", pulse_count, model_count);
    do_txn(100, 250, 1'b1, 2500);

    // Reset in the middle of ECHO aborts at once.
    echo_us = 16'd100;
    drive_trig(100, pf);
    wait_echo(1'b1, 400);
    repeat (50) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset_echo",  sonar_echo, 1'b0);
    check("async_reset_busy",  busy, 1'b0);
    check("async_reset_count", pulse_count, 8'd0);
    model_count = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    do_txn(100, 100, 1'b1, 1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
